// File: rtl/head_sram_pkg.sv
// Shared head_sram geometry and write-width encoding used by the head-side
// SRAM access logic.
package head_sram_pkg;

    localparam int unsigned HEAD_ADDR_W  = 9;
    localparam int unsigned HEAD_BANK_AW = 5;

    typedef enum logic [1:0] {
        WFLAG_FULL = 2'd0,
        WFLAG_BYTE = 2'd1,
        WFLAG_WORD = 2'd2
    } wflag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, skips masked requesters,
// pointer moves to winner+1 only when a grant is issued.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    always_comb begin
        int unsigned idx;
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx] && !mask[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/head_sram_arbiter.sv
// Shares one head_sram read/write port pair between NUM_REQ head cores:
// round-robin grants, registered SRAM commands, tagged read return, RAW stall.
module head_sram_arbiter
    import head_sram_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = HEAD_ADDR_W,
    parameter int unsigned BANK_AW    = HEAD_BANK_AW,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_gnt,
    output logic [NUM_REQ-1:0]            rd_rvalid,
    output logic [DATA_WIDTH-1:0]         rd_rdata,
    input  logic [NUM_REQ-1:0]            wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_REQ*2-1:0]          wr_flag,
    output logic [NUM_REQ-1:0]            wr_gnt,
    input  logic                          intf_busy,
    output logic                          sram_ren,
    output logic [ADDR_WIDTH-1:0]         sram_raddr,
    output logic                          sram_wen,
    output logic [ADDR_WIDTH-1:0]         sram_waddr,
    output logic [DATA_WIDTH-1:0]         sram_wdata,
    output logic [1:0]                    sram_wflag,
    input  logic [DATA_WIDTH-1:0]         sram_rdata
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    rd_mask;
    logic [NUM_REQ-1:0]    rd_raw_mask;
    logic [NUM_REQ-1:0]    wr_mask;
    logic                  rd_any;
    logic                  wr_any;
    logic [ADDR_WIDTH-1:0] rd_sel_addr;
    logic [IDW-1:0]        rd_sel_id;
    logic [ADDR_WIDTH-1:0] wr_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;
    logic [1:0]            wr_sel_flag;

    logic                  ren_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    wflag_t                wflag_q;

    logic [RD_LAT:0]       tag_v;
    logic [IDW-1:0]        tag_id [RD_LAT+1];

    // While the host interface owns the SRAM nobody is granted and pointers hold.
    assign wr_mask = {NUM_REQ{intf_busy}};
    assign rd_mask = rd_raw_mask | {NUM_REQ{intf_busy}};

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (wr_req),
        .mask (wr_mask),
        .gnt  (wr_gnt)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (rd_req),
        .mask (rd_mask),
        .gnt  (rd_gnt)
    );

    always_comb begin
        wr_any      = 1'b0;
        wr_sel_addr = '0;
        wr_sel_data = '0;
        wr_sel_flag = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                wr_any      = 1'b1;
                wr_sel_addr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_sel_data = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                wr_sel_flag = wr_flag[i*2 +: 2];
            end
        end
    end

    // head_sram commits one cycle after wen, so both this cycle's write grant and
    // the write currently on the SRAM port can still shadow a read of that bank_addr.
    always_comb begin
        logic [BANK_AW-1:0] ba;
        rd_raw_mask = '0;
        ba          = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ba             = rd_addr[i*ADDR_WIDTH +: BANK_AW];
            rd_raw_mask[i] = (wr_any && (ba == wr_sel_addr[BANK_AW-1:0])) ||
                             (wen_q  && (ba == waddr_q[BANK_AW-1:0]));
        end
    end

    always_comb begin
        rd_any      = 1'b0;
        rd_sel_addr = '0;
        rd_sel_id   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rd_gnt[i]) begin
                rd_any      = 1'b1;
                rd_sel_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                rd_sel_id   = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ren_q   <= 1'b0;
            raddr_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wflag_q <= WFLAG_FULL;
        end else begin
            ren_q <= rd_any;
            wen_q <= wr_any;
            if (rd_any) begin
                raddr_q <= rd_sel_addr;
            end
            if (wr_any) begin
                waddr_q <= wr_sel_addr;
                wdata_q <= wr_sel_data;
                wflag_q <= wflag_t'(wr_sel_flag);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_v <= '0;
            for (int unsigned k = 0; k <= RD_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= rd_any;
            tag_id[0] <= rd_sel_id;
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_comb begin
        rd_rvalid = '0;
        if (tag_v[RD_LAT]) begin
            rd_rvalid[tag_id[RD_LAT]] = 1'b1;
        end
    end

    assign rd_rdata   = sram_rdata;
    assign sram_ren   = ren_q;
    assign sram_raddr = raddr_q;
    assign sram_wen   = wen_q;
    assign sram_waddr = waddr_q;
    assign sram_wdata = wdata_q;
    assign sram_wflag = wflag_q;

endmodule

// File: tb/tb_head_sram_arbiter.sv
// Scoreboard bench for head_sram_arbiter: a request-level reference model predicts
// grants, SRAM commands and read returns; a negedge monitor checks the DUT outputs.
module tb_head_sram_arbiter;

    localparam int N   = 4;
    localparam int DW  = 128;
    localparam int AW  = 9;
    localparam int BAW = 5;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic [N-1:0]    rd_req, rd_gnt, rd_rvalid, wr_req, wr_gnt;
    logic [N*AW-1:0] rd_addr, wr_addr;
    logic [N*DW-1:0] wr_data;
    logic [N*2-1:0]  wr_flag;
    logic [DW-1:0]   rd_rdata, sram_wdata, sram_rdata;
    logic            intf_busy, sram_ren, sram_wen;
    logic [AW-1:0]   sram_raddr, sram_waddr;
    logic [1:0]      sram_wflag;

    always #5 clk = ~clk;

    head_sram_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_AW(BAW), .RD_LAT(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_flag(wr_flag),
        .wr_gnt(wr_gnt), .intf_busy(intf_busy),
        .sram_ren(sram_ren), .sram_raddr(sram_raddr),
        .sram_wen(sram_wen), .sram_waddr(sram_waddr),
        .sram_wdata(sram_wdata), .sram_wflag(sram_wflag),
        .sram_rdata(sram_rdata)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {4{23'h3C0F0, a}};
    endfunction

    // head_sram stand-in: 1-cycle read, write committed one cycle after wen
    logic [DW-1:0] mem [512];
    bit            written [512];
    logic          pend_v = 1'b0;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= written[sram_raddr] ? mem[sram_raddr] : init_word(sram_raddr);
        if (pend_v) begin
            mem[pend_a]     <= pend_d;
            written[pend_a] <= 1'b1;
        end
        pend_v <= sram_wen;
        pend_a <= sram_waddr;
        pend_d <= sram_wdata;
    end

    typedef struct {
        int            due;
        bit            ren;
        logic [AW-1:0] ra;
        bit            wen;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [1:0]    wf;
    } cmd_t;
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] d;
    } rv_t;

    cmd_t cmd_q[$];
    rv_t  rv_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int            rptr = 0, wptr = 0;
    bit            rd_pend [N];
    logic [AW-1:0] rd_a [N];
    bit            wr_pend [N];
    logic [AW-1:0] wr_a [N];
    logic [DW-1:0] wr_d [N];
    logic [1:0]    wr_f [N];
    bit            last_wv = 1'b0;
    logic [AW-1:0] last_wa;
    logic [DW-1:0] shadow [int];
    logic [N-1:0]  last_rd_gnt, last_wr_gnt;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input bit [N-1:0] cand, input int p);
        for (int k = 0; k < N; k++) begin
            if (cand[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (rd_pend[i] || wr_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
    endtask

    task automatic step(input bit busy);
        int rg, wg;
        bit [N-1:0] rc, wc;
        cmd_t c;
        rv_t r;
        tick();
        #1;
        for (int i = 0; i < N; i++) begin
            rd_req[i]            = rd_pend[i];
            rd_addr[i*AW +: AW]  = rd_a[i];
            wr_req[i]            = wr_pend[i];
            wr_addr[i*AW +: AW]  = wr_a[i];
            wr_data[i*DW +: DW]  = wr_d[i];
            wr_flag[i*2 +: 2]    = wr_f[i];
        end
        intf_busy = busy;
        for (int i = 0; i < N; i++) wc[i] = wr_pend[i] && !busy;
        wg = pick(wc, wptr);
        for (int i = 0; i < N; i++) begin
            rc[i] = rd_pend[i] && !busy
                 && !(wg >= 0 && rd_a[i][BAW-1:0] == wr_a[wg][BAW-1:0])
                 && !(last_wv && rd_a[i][BAW-1:0] == last_wa[BAW-1:0]);
        end
        rg = pick(rc, rptr);
        #1;
        last_rd_gnt = rd_gnt;
        last_wr_gnt = wr_gnt;
        chk("rd_gnt", rd_gnt, (rg >= 0) ? DW'(1) << rg : '0);
        chk("wr_gnt", wr_gnt, (wg >= 0) ? DW'(1) << wg : '0);
        c = '{due: cyc + 1, ren: (rg >= 0), ra: '0, wen: (wg >= 0), wa: '0, wd: '0, wf: '0};
        if (rg >= 0) begin
            c.ra = rd_a[rg];
            r.due = cyc + 2;
            r.id  = rg;
            r.d   = shadow.exists(int'(rd_a[rg])) ? shadow[int'(rd_a[rg])] : init_word(rd_a[rg]);
            rv_q.push_back(r);
            rd_pend[rg] = 1'b0;
            rptr = (rg + 1) % N;
        end
        if (wg >= 0) begin
            c.wa = wr_a[wg];
            c.wd = wr_d[wg];
            c.wf = wr_f[wg];
            shadow[int'(wr_a[wg])] = wr_d[wg];
            wr_pend[wg] = 1'b0;
            wptr = (wg + 1) % N;
            last_wv = 1'b1;
            last_wa = wr_a[wg];
        end else begin
            last_wv = 1'b0;
        end
        cmd_q.push_back(c);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (any_pend() && n < maxc) begin
            step(1'b0);
            n++;
        end
        chk("drain_done", DW'(any_pend()), '0);
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [1:0] f);
        wr_pend[i] = 1'b1;
        wr_a[i]    = a;
        wr_d[i]    = {$urandom, $urandom, $urandom, $urandom};
        wr_f[i]    = f;
    endtask

    // monitor: SRAM command and read return checked against the scoreboard queues
    initial begin
        cmd_t c;
        rv_t  r;
        forever begin
            @(negedge clk);
            if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
                c = cmd_q.pop_front();
                chk("sram_ren", DW'(sram_ren), DW'(c.ren));
                chk("sram_wen", DW'(sram_wen), DW'(c.wen));
                if (c.ren) chk("sram_raddr", DW'(sram_raddr), DW'(c.ra));
                if (c.wen) begin
                    chk("sram_waddr", DW'(sram_waddr), DW'(c.wa));
                    chk("sram_wdata", sram_wdata, c.wd);
                    chk("sram_wflag", DW'(sram_wflag), DW'(c.wf));
                end
            end else begin
                chk("sram_ren_idle", DW'(sram_ren), '0);
                chk("sram_wen_idle", DW'(sram_wen), '0);
            end
            if (rv_q.size() > 0 && rv_q[0].due == cyc) begin
                r = rv_q.pop_front();
                chk("rd_rvalid", DW'(rd_rvalid), DW'(1) << r.id);
                chk("rd_rdata", rd_rdata, r.d);
            end else begin
                chk("rd_rvalid_idle", DW'(rd_rvalid), '0);
            end
        end
    end

    initial begin
        rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0;
        wr_data = '0; wr_flag = '0; intf_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_pend[i] = 1'b0; wr_pend[i] = 1'b0;
            rd_a[i] = '0; wr_a[i] = '0; wr_d[i] = '0; wr_f[i] = '0;
        end
        #2 rstn = 1'b0;
        repeat (3) tick();
        #1 rstn = 1'b1;

        @(negedge clk);
        chk("rst_rd_gnt", DW'(rd_gnt), '0);
        chk("rst_wr_gnt", DW'(wr_gnt), '0);
        chk("rst_rvalid", DW'(rd_rvalid), '0);
        chk("rst_ren", DW'(sram_ren), '0);
        chk("rst_wen", DW'(sram_wen), '0);
        chk("rst_raddr", DW'(sram_raddr), '0);
        chk("rst_waddr", DW'(sram_waddr), '0);
        chk("rst_wdata", sram_wdata, '0);
        chk("rst_wflag", DW'(sram_wflag), '0);

        // single read, preloaded word returned two cycles after grant
        rd_pend[2] = 1'b1; rd_a[2] = 9'h045;
        step(1'b0);
        chk("single_rd_gnt", DW'(last_rd_gnt), DW'(4'b0100));
        repeat (3) step(1'b0);

        // reset while a read is in flight: no return, pointers back to 0
        rd_pend[1] = 1'b1; rd_a[1] = 9'h0AB;
        step(1'b0);
        tick();
        #1 rstn = 1'b0;
        rd_req = '0;
        cmd_q.delete(); rv_q.delete();
        rptr = 0; wptr = 0; last_wv = 1'b0;
        tick(); tick();
        #1 rstn = 1'b1;
        repeat (4) step(1'b0);

        // fairness: everybody requesting, grants rotate from 0
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                rd_pend[i] = 1'b1; rd_a[i] = AW'(9'h060 + i);
            end
            step(1'b0);
            chk("fair_order", DW'(last_rd_gnt), DW'(1) << (k % N));
        end
        drain(20);
        repeat (2) step(1'b0);

        // RAW: read of the just-written bank_addr stalls one cycle
        set_wr(0, 9'h013, 2'd0);
        step(1'b0);
        rd_pend[1] = 1'b1; rd_a[1] = 9'h113;
        step(1'b0);
        chk("raw_stall", DW'(last_rd_gnt), '0);
        step(1'b0);
        chk("raw_release", DW'(last_rd_gnt), DW'(4'b0010));
        set_wr(2, 9'h0C7, 2'd0);
        step(1'b0);
        step(1'b0);
        rd_pend[3] = 1'b1; rd_a[3] = 9'h0C7;
        repeat (4) step(1'b0);

        // host override: all request, nothing granted for 3 cycles
        for (int i = 0; i < N; i++) begin
            rd_pend[i] = 1'b1; rd_a[i] = AW'(9'h020 + i);
            set_wr(i, AW'(9'h048 + i), 2'(i % 3));
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            chk("busy_rd_gnt", DW'(last_rd_gnt), '0);
            chk("busy_wr_gnt", DW'(last_wr_gnt), '0);
        end
        drain(20);
        repeat (2) step(1'b0);

        // concurrent read and byte write from the same requester
        set_wr(3, 9'h1A0, 2'd1);
        rd_pend[3] = 1'b1; rd_a[3] = 9'h005;
        step(1'b0);
        chk("conc_rd_gnt", DW'(last_rd_gnt), DW'(4'b1000));
        chk("conc_wr_gnt", DW'(last_wr_gnt), DW'(4'b1000));
        repeat (3) step(1'b0);

        // randomized traffic over a small bank_addr set to provoke hazards
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!rd_pend[i] && $urandom_range(0, 2) == 0) begin
                    rd_pend[i] = 1'b1;
                    rd_a[i] = {4'($urandom_range(0, 15)), 5'($urandom_range(0, 3))};
                end
                if (!wr_pend[i] && $urandom_range(0, 2) == 0)
                    set_wr(i, {4'($urandom_range(0, 15)), 5'($urandom_range(0, 3))},
                           2'($urandom_range(0, 2)));
            end
            step($urandom_range(0, 9) == 0);
        end
        drain(40);
        repeat (3) step(1'b0);
        chk("rv_q_empty", DW'(rv_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
